trapez_peak_sampler: RTL and testbench
======================================

# trapez_peak_sampler

Event extractor on the output side of the trapezoidal shaper: consumes the shaped, signed trapezoid sample stream per channel, detects threshold crossings, captures the peak (flat-top) amplitude as event energy with a sample timestamp, flags pile-up, and presents each event to downstream logic through a valid/ready handshake. One instance per channel.

## Interface
- DATA_WIDTH, FULL_SIZE (26): width of the signed shaper output sample and of the energy.
- RISE_LEN, 20: trapezoid rise length in samples, equal to min(K, L).
- FLAT_LEN, 5: trapezoid flat-top length in samples, equal to |K − L|.
- TAIL_MAX, 40: maximum above-threshold tail samples before pile-up is declared.
- TS_WIDTH, 32: timestamp width.
- clk  in  1  system clock; all logic rising-edge.
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  arms new triggers; an event in progress always completes.
- data_in  in  DATA_WIDTH  signed shaper output sample.
- data_valid_in  in  1  data_in qualifier; only valid samples advance any counter.
- threshold  in  DATA_WIDTH  signed trigger level, quasi-static.
- energy_out  out  DATA_WIDTH  signed peak value of the event window.
- timestamp_out  out  TS_WIDTH  sample index of the crossing sample.
- pileup_out  out  1  event tail exceeded TAIL_MAX.
- event_valid  out  1  output event held.
- event_ready  in  1  downstream accepts the event.
- drop_count  out  16  saturating count of lost events.
- busy  out  1  high whenever the FSM is not IDLE.

## Operation
- Sample counter: TS_WIDTH bits, increments on every valid sample, wraps to 0.
- below_prev: registered (data_in < threshold) of the last valid sample; reset value 1.
- Window length W = RISE_LEN + FLAT_LEN.
- FSM states IDLE, WINDOW, TAIL:
  - IDLE: valid, enable, below_prev = 1 and data_in >= threshold -> WINDOW; cnt = 1, peak = data_in, ts = current sample index.
  - WINDOW: each valid sample, peak = signed max(peak, data_in), cnt++. On the sample with cnt reaching W -> TAIL, tail_cnt = 0. Dropping below threshold inside the window does not abort the event.
  - TAIL: valid sample < threshold -> emit (pileup = 0), go to IDLE. Otherwise tail_cnt++. When tail_cnt reaches TAIL_MAX, emit (pileup = 1) and go to IDLE. below_prev stays 0, so no retrigger occurs until the signal falls below threshold.
- Emit:
  - If !event_valid or event_ready in that cycle, load energy/timestamp/pileup and set event_valid.
  - Otherwise the new event is discarded and drop_count increments, saturating at 0xFFFF.
- Handshake: event_valid stays high, with stable outputs, until a cycle with event_ready = 1. It then clears unless a new event loads in the same cycle, in which case it stays high with the new contents.
- Comparisons and max are signed, with no width growth.
- Reset values, with reset_n asynchronous: FSM IDLE, all counters 0, below_prev 1, event_valid 0, energy_out 0, timestamp_out 0, pileup_out 0, drop_count 0, busy 0.
- Reset mid-event: the event is lost without being counted.

## Timing
- event_valid rises one clock after the edge that samples the terminating tail sample, either the first below-threshold sample or the TAIL_MAX-th above-threshold sample.
- Minimum event spacing: W + 1 valid samples.
- Idle cycles (data_valid_in = 0) freeze all state.
- Throughput: one sample per clock.

## Configuration
- TRAPEZ_PILEUP_REJECT_EN defined: pile-up events are never emitted. They increment drop_count instead, and pileup_out is tied 0.
- Undefined: pile-up events are emitted with pileup_out = 1.

## Structure
- settings_pkg gains:
  - RISE_LEN, FLAT_LEN, TAIL_MAX, TS_WIDTH constants.
  - typedef enum sampler_state_t {IDLE, WINDOW, TAIL}.
  - typedef struct packed trapez_event_t {energy, timestamp, pileup}.
- One sub-module, trapez_event_slot: the single-entry valid/ready output register with drop-counter logic.

## Test plan
- threshold = 100; trapezoid rising 0 -> 2000 over 20 samples, flat 25 samples, back to 0; crossing at sample index 7 -> one event with energy 2000, timestamp 7, pileup 0, drop_count 0.
- Same pulse with event_ready held 0, then a second pulse -> first event held stable, second discarded, drop_count = 1. Then event_ready = 1 for one cycle -> event_valid falls.
- Signal held at 1500 for 100 samples after crossing -> pileup event after 25 + 40 samples, no retrigger until below 100. With TRAPEZ_PILEUP_REJECT_EN: no event and drop_count = 1.
- enable = 0 during a pulse -> no event. enable deasserted mid-WINDOW -> event still completes.
- reset_n pulsed low mid-WINDOW -> all outputs at reset values immediately, no event. The next pulse is captured correctly.
- Negative threshold −50 with a negative-going input -> signed compare verified. Timestamp wrap from 0xFFFFFFFF to 0 is reported correctly.

Source files
------------

// File: rtl/trapez_peak_sampler_pkg.sv
// trapez_peak_sampler_pkg: shared constants, FSM state and event record for the trapezoid peak sampler.
package trapez_peak_sampler_pkg;
  localparam int FULL_SIZE = 26;
  localparam int RISE_LEN  = 20;
  localparam int FLAT_LEN  = 5;
  localparam int TAIL_MAX  = 40;
  localparam int TS_WIDTH  = 32;
  localparam int WIN_LEN   = RISE_LEN + FLAT_LEN;
  typedef enum logic [1:0] {IDLE, WINDOW, TAIL} sampler_state_t;
  typedef struct packed {
    logic signed [FULL_SIZE-1:0] energy;
    logic [TS_WIDTH-1:0]         timestamp;
    logic                        pileup;
  } trapez_event_t;
endpackage

// File: rtl/trapez_event_slot.sv
// trapez_event_slot: single-entry valid/ready event register with a saturating lost-event counter.
module trapez_event_slot
  import trapez_peak_sampler_pkg::*;
(
  input  logic          clk,
  input  logic          reset_n,
  input  logic          push,
  input  logic          discard,
  input  trapez_event_t ev_in,
  input  logic          event_ready,
  output trapez_event_t ev_out,
  output logic          event_valid,
  output logic [15:0]   drop_count
);
  logic          valid_q, valid_d, load;
  trapez_event_t ev_q, ev_d;
  logic [15:0]   drop_q, drop_d;
  always_comb begin
    load    = push && (!valid_q || event_ready);
    valid_d = load || (valid_q && !event_ready);
    ev_d    = load ? ev_in : ev_q;
    drop_d  = ((push && !load) || discard) && drop_q != 16'hFFFF ? drop_q + 16'd1 : drop_q;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      valid_q <= 1'b0;
      ev_q    <= '0;
      drop_q  <= '0;
    end else begin
      valid_q <= valid_d;
      ev_q    <= ev_d;
      drop_q  <= drop_d;
    end
  assign ev_out      = ev_q;
  assign event_valid = valid_q;
  assign drop_count  = drop_q;
endmodule

// File: rtl/trapez_peak_sampler.sv
// trapez_peak_sampler: threshold trigger, flat-top peak capture, pile-up flag and event handshake.
// TRAPEZ_PILEUP_REJECT_EN: pile-up events are dropped (counted in drop_count) instead of emitted.
module trapez_peak_sampler
  import trapez_peak_sampler_pkg::*;
(
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        enable,
  input  logic signed [FULL_SIZE-1:0] data_in,
  input  logic                        data_valid_in,
  input  logic signed [FULL_SIZE-1:0] threshold,
  output logic signed [FULL_SIZE-1:0] energy_out,
  output logic [TS_WIDTH-1:0]         timestamp_out,
  output logic                        pileup_out,
  output logic                        event_valid,
  input  logic                        event_ready,
  output logic [15:0]                 drop_count,
  output logic                        busy
);
  localparam int CW = $clog2(WIN_LEN + 1);
  localparam int TW = $clog2(TAIL_MAX + 1);
  sampler_state_t              state_q, state_d;
  logic [TS_WIDTH-1:0]         sidx_q, sidx_d, ts_q, ts_d;
  logic                        below_prev_q, below_prev_d, emit_q, emit_d, below;
  logic [CW-1:0]               cnt_q, cnt_d;
  logic [TW-1:0]               tail_q, tail_d;
  logic signed [FULL_SIZE-1:0] peak_q, peak_d;
  trapez_event_t               ev_q, ev_d, slot_in, slot_out;
  logic                        push, discard;
  assign below = data_in < threshold;
  always_comb begin
    state_d      = state_q;
    sidx_d       = sidx_q;
    below_prev_d = below_prev_q;
    cnt_d        = cnt_q;
    tail_d       = tail_q;
    peak_d       = peak_q;
    ts_d         = ts_q;
    emit_d       = 1'b0;
    ev_d         = ev_q;
    if (data_valid_in) begin
      sidx_d       = sidx_q + 1'b1;
      below_prev_d = below;
      case (state_q)
        IDLE: if (enable && below_prev_q && !below) begin
          state_d = WINDOW;
          cnt_d   = CW'(1);
          peak_d  = data_in;
          ts_d    = sidx_q;
        end
        WINDOW: begin
          peak_d = data_in > peak_q ? data_in : peak_q;
          cnt_d  = cnt_q + 1'b1;
          if (cnt_d == CW'(WIN_LEN)) begin
            state_d = TAIL;
            tail_d  = '0;
          end
        end
        TAIL: begin
          tail_d = tail_q + 1'b1;
          if (below || tail_d == TW'(TAIL_MAX)) begin
            state_d = IDLE;
            emit_d  = 1'b1;
            ev_d    = '{energy: peak_q, timestamp: ts_q, pileup: !below};
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q      <= IDLE;
      sidx_q       <= '0;
      below_prev_q <= 1'b1;
      cnt_q        <= '0;
      tail_q       <= '0;
      peak_q       <= '0;
      ts_q         <= '0;
      emit_q       <= 1'b0;
      ev_q         <= '0;
    end else begin
      state_q      <= state_d;
      sidx_q       <= sidx_d;
      below_prev_q <= below_prev_d;
      cnt_q        <= cnt_d;
      tail_q       <= tail_d;
      peak_q       <= peak_d;
      ts_q         <= ts_d;
      emit_q       <= emit_d;
      ev_q         <= ev_d;
    end
`ifdef TRAPEZ_PILEUP_REJECT_EN
  assign push    = emit_q && !ev_q.pileup;
  assign discard = emit_q && ev_q.pileup;
  assign slot_in = '{energy: ev_q.energy, timestamp: ev_q.timestamp, pileup: 1'b0};
`else
  assign push    = emit_q;
  assign discard = 1'b0;
  assign slot_in = ev_q;
`endif
  trapez_event_slot u_slot (
    .clk         (clk),
    .reset_n     (reset_n),
    .push        (push),
    .discard     (discard),
    .ev_in       (slot_in),
    .event_ready (event_ready),
    .ev_out      (slot_out),
    .event_valid (event_valid),
    .drop_count  (drop_count)
  );
  assign energy_out    = slot_out.energy;
  assign timestamp_out = slot_out.timestamp;
  assign pileup_out    = slot_out.pileup;
  assign busy          = state_q != IDLE;
endmodule

// File: tb/tb_trapez_peak_sampler.sv
// tb_trapez_peak_sampler: directed pulses with hand-computed event energy, timestamp, pile-up and drop counts.
module tb_trapez_peak_sampler;
  import trapez_peak_sampler_pkg::*;
  logic                        clk = 0, reset_n = 0, enable = 0, data_valid_in = 0, event_ready = 1;
  logic signed [FULL_SIZE-1:0] data_in = '0, threshold = 100;
  logic signed [FULL_SIZE-1:0] energy_out;
  logic [TS_WIDTH-1:0]         timestamp_out;
  logic                        pileup_out, event_valid, busy;
  logic [15:0]                 drop_count;
  int                          total = 0, bad = 0, n_acc = 0;
  int unsigned                 nsent = 0, ts, ts2;
  logic signed [FULL_SIZE-1:0] acc_en = '0;
  logic [TS_WIDTH-1:0]         acc_ts = '0;
  logic                        acc_pu = 0;
  always #5 clk = ~clk;
  trapez_peak_sampler dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .data_in(data_in),
    .data_valid_in(data_valid_in), .threshold(threshold), .energy_out(energy_out),
    .timestamp_out(timestamp_out), .pileup_out(pileup_out), .event_valid(event_valid),
    .event_ready(event_ready), .drop_count(drop_count), .busy(busy)
  );
  always @(negedge clk)
    if (reset_n && event_valid && event_ready) begin
      n_acc++;
      acc_en = energy_out;
      acc_ts = timestamp_out;
      acc_pu = pileup_out;
    end
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic send(input int v);
    @(posedge clk); #1;
    data_in = FULL_SIZE'(v);
    data_valid_in = 1;
    nsent++;
  endtask
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      data_valid_in = 0;
    end
  endtask
  task automatic pulse(input int lead, input int peak, input int flat, input int en_off, output int unsigned t);
    repeat (lead) send(0);
    t = nsent;
    for (int i = 1; i <= 20; i++) begin
      send(peak * i / 20);
      if (i == en_off) enable = 0;
    end
    repeat (flat) send(peak);
    for (int i = 19; i >= 0; i--) send(peak * i / 20);
    idle(4);
  endtask
  initial begin
    enable = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", event_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_drop", drop_count, 0);
    chk("rst_energy", energy_out, 0);
    chk("rst_ts", timestamp_out, 0);
    chk("rst_pu", pileup_out, 0);
    reset_n = 1;
    // basic pulse, crossing at sample index 7
    pulse(7, 2000, 25, -1, ts);
    chk("t1_count", n_acc, 1);
    chk("t1_energy", acc_en, 2000);
    chk("t1_ts", acc_ts, 7);
    chk("t1_pu", acc_pu, 0);
    chk("t1_drop", drop_count, 0);
    // back-pressure: first event held, second dropped
    event_ready = 0;
    pulse(3, 2000, 25, -1, ts);
    chk("t2_valid", event_valid, 1);
    chk("t2_ts_a", timestamp_out, 64'(ts));
    pulse(3, 2000, 25, -1, ts2);
    chk("t2_hold_valid", event_valid, 1);
    chk("t2_hold_ts", timestamp_out, 64'(ts));
    chk("t2_hold_en", energy_out, 2000);
    chk("t2_drop", drop_count, 1);
    @(posedge clk); #1 event_ready = 1;
    @(posedge clk); #1 event_ready = 0;
    @(negedge clk);
    chk("t2_cleared", event_valid, 0);
    chk("t2_count", n_acc, 2);
    event_ready = 1;
    // pile-up: 1500 held for 100 samples
    repeat (2) send(0);
    ts = nsent;
    repeat (66) send(1500);
    @(negedge clk);
    chk("t3_early", event_valid, 0);
    send(1500);
    @(negedge clk);
`ifdef TRAPEZ_PILEUP_REJECT_EN
    chk("t3_lat", event_valid, 0);
`else
    chk("t3_lat", event_valid, 1);
`endif
    repeat (33) send(1500);
    repeat (30) send(0);
    idle(4);
`ifdef TRAPEZ_PILEUP_REJECT_EN
    chk("t3_count", n_acc, 2);
    chk("t3_drop", drop_count, 2);
`else
    chk("t3_count", n_acc, 3);
    chk("t3_energy", acc_en, 1500);
    chk("t3_ts", acc_ts, 64'(ts));
    chk("t3_pu", acc_pu, 1);
    chk("t3_drop", drop_count, 1);
`endif
    // enable low for the whole pulse, then dropped mid-window
    ts2 = n_acc;
    enable = 0;
    pulse(3, 2000, 25, -1, ts);
    chk("t4_disabled", n_acc, 64'(ts2));
    chk("t4_busy", busy, 0);
    enable = 1;
    pulse(3, 2000, 25, 5, ts);
    enable = 1;
    chk("t4_midwin_count", n_acc, 64'(ts2 + 1));
    chk("t4_midwin_ts", acc_ts, 64'(ts));
    chk("t4_midwin_en", acc_en, 2000);
    // asynchronous reset mid-window
    ts2 = n_acc;
    repeat (2) send(0);
    for (int i = 1; i <= 10; i++) send(100 * i);
    @(negedge clk);
    chk("t5_busy", busy, 1);
    reset_n = 0;
    data_valid_in = 0;
    #1;
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_valid", event_valid, 0);
    chk("t5_rst_drop", drop_count, 0);
    chk("t5_rst_energy", energy_out, 0);
    chk("t5_rst_ts", timestamp_out, 0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1;
    nsent = 0;
    pulse(4, 2000, 25, -1, ts);
    chk("t5_count", n_acc, 64'(ts2 + 1));
    chk("t5_ts", acc_ts, 4);
    chk("t5_energy", acc_en, 2000);
    // negative threshold and signed max
    threshold = -50;
    ts2 = n_acc;
    repeat (3) send(-400);
    ts = nsent;
    send(-45);
    send(30);
    repeat (23) send(-20);
    repeat (4) send(-400);
    idle(4);
    chk("t6_count", n_acc, 64'(ts2 + 1));
    chk("t6_energy", acc_en, 30);
    chk("t6_ts", acc_ts, 64'(ts));
    chk("t6_pu", acc_pu, 0);
    // timestamp wrap: crossing lands on index 0 after 0xFFFFFFFF
    threshold = 100;
    ts2 = n_acc;
    force dut.sidx_q = 32'hFFFF_FFFE;
    @(negedge clk);
    release dut.sidx_q;
    pulse(2, 2000, 25, -1, ts);
    chk("t7_count", n_acc, 64'(ts2 + 1));
    chk("t7_ts_wrap", acc_ts, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
